// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch stage: program memory, loader port and RUN stream with stall/redirect
module inst_fetch_unit #(
    parameter int          IMEM_DEPTH = 64,
    parameter int          AW         = $clog2(IMEM_DEPTH),
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          start,
    input  logic [AW:0]   prog_len,
    input  logic          stall,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic [31:0]   inst,
    output logic [31:0]   inst_pc,
    output logic          inst_valid,
    output logic          busy,
    output logic          done,
    output logic          fault
);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(IMEM_DEPTH);

    logic [31:0] mem [IMEM_DEPTH];

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [AW:0] len_q, len_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic        wr_en;

    logic [31:0] pc_off;
    logic [31:0] idx_full;
    logic        in_range;

    // The range check is done on the full 32-bit offset so a wrapped pc or a
    // far forward redirect can never alias back into the memory.
    assign pc_off   = pc_q - RESET_PC;
    assign idx_full = pc_off >> 2;
    assign in_range = (pc_q >= RESET_PC) && (idx_full < 32'(len_q));

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        len_d     = len_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        wr_en     = 1'b0;
        case (state_q)
            S_LOAD, S_DONE: begin
                inst_d  = NOP_INST;
                valid_d = 1'b0;
                if (load_en) begin
                    wr_en = 1'b1;
                end else if (start) begin
                    len_d   = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
                    pc_d    = RESET_PC;
                    fault_d = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (redirect) begin
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                    if ((redirect_pc[1:0] != 2'b00) || (redirect_pc < RESET_PC)) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (!stall) begin
                    if (in_range) begin
                        inst_d    = mem[idx_full[AW-1:0]];
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        pc_d      = pc_q + 32'd4;
                    end else begin
                        inst_d  = NOP_INST;
                        valid_d = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q   <= S_LOAD;
            pc_q      <= RESET_PC;
            len_q     <= '0;
            inst_q    <= NOP_INST;
            inst_pc_q <= 32'd0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            len_q     <= len_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
        end
    end

    // Program image survives reset, so the memory has no reset branch.
    always_ff @(posedge cpu_clk) begin
        if (wr_en) begin
            mem[load_addr] <= load_data;
        end
    end

    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = valid_q;
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign fault      = fault_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

    localparam int          DEPTH = 64;
    localparam int          AW    = 6;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          cpu_clk = 1'b0;
    logic          cpu_rst = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = '0;
    logic          start = 1'b0;
    logic [AW:0]   prog_len = '0;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic [31:0]   inst, inst_pc;
    logic          inst_valid, busy, done, fault;

    inst_fetch_unit #(.IMEM_DEPTH(DEPTH)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .prog_len(prog_len), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .inst(inst), .inst_pc(inst_pc),
        .inst_valid(inst_valid), .busy(busy), .done(done), .fault(fault)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct { logic [31:0] pc; logic [31:0] w; int c; } ent_t;
    ent_t log_q[$];

    logic [31:0] prog [5] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h40000233, 32'h00500293};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: program counter walks a word array while running.
    logic [31:0] mm [DEPTH];
    logic        m_running, m_finished, m_fault, m_val;
    logic [31:0] m_pc, m_inst, m_ipc;
    int          m_len;

    always @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            m_running = 0; m_finished = 0; m_fault = 0; m_val = 0;
            m_pc = 0; m_inst = NOP; m_ipc = 0; m_len = 0;
        end else if (!m_running) begin
            if (load_en) mm[load_addr] = load_data;
            else if (start) begin
                m_len = (int'(prog_len) > DEPTH) ? DEPTH : int'(prog_len);
                m_pc = 0; m_fault = 0; m_running = 1; m_finished = 0;
            end
        end else if (redirect) begin
            m_inst = NOP; m_val = 0;
            if (redirect_pc % 4 != 0) begin
                m_fault = 1; m_running = 0; m_finished = 1;
            end else m_pc = redirect_pc;
        end else if (!stall) begin
            if (longint'(m_pc) / 4 < longint'(m_len)) begin
                m_inst = mm[m_pc / 4]; m_ipc = m_pc; m_val = 1; m_pc = m_pc + 4;
            end else begin
                m_inst = NOP; m_val = 0; m_running = 0; m_finished = 1;
            end
        end
    end

    always @(negedge cpu_clk) begin
        cyc++;
        chk("inst", inst, m_inst);
        chk("inst_pc", inst_pc, m_ipc);
        chk("inst_valid", 32'(inst_valid), 32'(m_val));
        chk("busy", 32'(busy), 32'(m_running));
        chk("done", 32'(done), 32'(m_finished));
        chk("fault", 32'(fault), 32'(m_fault));
        if (inst_valid) log_q.push_back('{inst_pc, inst, cyc});
    end

    task automatic load_prog();
        for (int i = 0; i < 5; i++) begin
            @(negedge cpu_clk);
            load_en = 1; load_addr = AW'(i); load_data = prog[i];
        end
        @(negedge cpu_clk);
        load_en = 0;
    endtask

    task automatic do_start(input int len);
        @(negedge cpu_clk);
        start = 1; prog_len = (AW+1)'(len);
        @(negedge cpu_clk);
        start = 0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 200) begin
            @(negedge cpu_clk);
            k++;
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s: done not seen within 200 cycles", name);
        end
    endtask

    task automatic wait_valid_pc(input logic [31:0] pc);
        int k = 0;
        while (!(inst_valid && inst_pc == pc) && k < 50) begin
            @(negedge cpu_clk);
            k++;
        end
        chk("wait_valid_pc", inst_pc, pc);
    endtask

    task automatic chk_log(input string name, input logic [31:0] pcs[$], input logic [31:0] ws[$]);
        chk({name, "_len"}, 32'(log_q.size()), 32'(pcs.size()));
        for (int i = 0; i < pcs.size() && i < log_q.size(); i++) begin
            chk({name, "_pc"}, log_q[i].pc, pcs[i]);
            chk({name, "_w"}, log_q[i].w, ws[i]);
        end
    endtask

    initial begin
        #1 cpu_rst = 1;
        repeat (2) @(negedge cpu_clk);
        chk("rst_inst", inst, NOP);
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        cpu_rst = 0;

        // 1: basic stream
        load_prog();
        log_q.delete();
        do_start(5);
        wait_done("t1");
        chk_log("t1", '{0, 4, 8, 32'hC, 32'h10}, '{prog[0], prog[1], prog[2], prog[3], prog[4]});
        chk("t1_inst_end", inst, 32'h00000013);
        chk("t1_busy_end", 32'(busy), 0);

        // 2: stall for two cycles on the third word
        log_q.delete();
        do_start(5);
        wait_valid_pc(8);
        stall = 1;
        repeat (2) @(negedge cpu_clk);
        stall = 0;
        wait_done("t2");
        chk_log("t2", '{0, 4, 8, 8, 8, 32'hC, 32'h10},
                '{prog[0], prog[1], prog[2], prog[2], prog[2], prog[3], prog[4]});
        if (log_q.size() == 7) chk("t2_span", 32'(log_q[6].c - log_q[0].c + 1), 7);

        // 3: backward redirect
        log_q.delete();
        do_start(5);
        wait_valid_pc(8);
        redirect = 1; redirect_pc = 32'h4;
        @(negedge cpu_clk);
        redirect = 0;
        chk("t3_bubble_valid", 32'(inst_valid), 0);
        chk("t3_bubble_inst", inst, NOP);
        wait_done("t3");
        chk_log("t3", '{0, 4, 8, 4, 8, 32'hC, 32'h10},
                '{prog[0], prog[1], prog[2], prog[1], prog[2], prog[3], prog[4]});

        // 4a: misaligned redirect then restart
        do_start(5);
        wait_valid_pc(4);
        redirect = 1; redirect_pc = 32'h6;
        @(negedge cpu_clk);
        redirect = 0;
        chk("t4_fault", 32'(fault), 1);
        chk("t4_done", 32'(done), 1);
        chk("t4_valid", 32'(inst_valid), 0);
        log_q.delete();
        do_start(5);
        chk("t4_fault_clr", 32'(fault), 0);
        wait_done("t4a");
        chk("t4_rerun_len", 32'(log_q.size()), 5);

        // 4b: zero length
        do_start(0);
        chk("t4_zero_busy", 32'(busy), 1);
        chk("t4_zero_valid", 32'(inst_valid), 0);
        @(negedge cpu_clk);
        chk("t4_zero_done", 32'(done), 1);

        // 5: asynchronous reset mid-run, then restart without reload
        do_start(5);
        wait_valid_pc(4);
        #2 cpu_rst = 1;
        #1;
        chk("t5_inst", inst, NOP);
        chk("t5_pc", inst_pc, 0);
        chk("t5_valid", 32'(inst_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        @(negedge cpu_clk);
        cpu_rst = 0;
        log_q.delete();
        do_start(5);
        wait_done("t5");
        chk_log("t5", '{0, 4, 8, 32'hC, 32'h10}, '{prog[0], prog[1], prog[2], prog[3], prog[4]});

        // 6: load/start collision, then load attempt during RUN
        @(negedge cpu_clk);
        load_en = 1; load_addr = 6'd5; load_data = 32'h00600313;
        start = 1; prog_len = 7'd6;
        @(negedge cpu_clk);
        load_en = 0; start = 0;
        chk("t6_busy", 32'(busy), 0);
        do_start(6);
        load_en = 1; load_addr = 6'd3; load_data = 32'hDEADBEEF;
        @(negedge cpu_clk);
        load_en = 0;
        wait_done("t6a");
        log_q.delete();
        do_start(6);
        wait_done("t6b");
        chk_log("t6", '{0, 4, 8, 32'hC, 32'h10, 32'h14},
                '{prog[0], prog[1], prog[2], prog[3], prog[4], 32'h00600313});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
